// File: rtl/hack_pkg.sv
// Shared types and instruction-field constants for the Hack CPU controller.
package hack_pkg;

    localparam int unsigned WORD_W  = 16;

    // Instruction field bit positions
    localparam int unsigned IB_TYPE = 15;
    localparam int unsigned IB_A    = 12;
    localparam int unsigned COMP_HI = 11;
    localparam int unsigned COMP_LO = 6;
    localparam int unsigned DEST_HI = 5;
    localparam int unsigned DEST_LO = 3;
    localparam int unsigned JUMP_HI = 2;
    localparam int unsigned JUMP_LO = 0;

    // Individual destination bits
    localparam int unsigned DB_A    = 5;
    localparam int unsigned DB_D    = 4;
    localparam int unsigned DB_M    = 3;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [2:0] {
        FETCH = 3'd0,
        MEMRD = 3'd1,
        EXEC  = 3'd2,
        MEMWR = 3'd3,
        WB    = 3'd4,
        HALT  = 3'd5
    } state_t;

    // True for C-instructions (compute form)
    function automatic logic is_c_instr(input word_t instr);
        return instr[IB_TYPE];
    endfunction

endpackage

// File: rtl/hack_cpu_ctrl_if.sv
// Instruction memory, data memory and ALU connections of the Hack controller.
interface hack_cpu_ctrl_if;
    import hack_pkg::*;

    logic  imem_req;
    word_t imem_addr;
    logic  imem_ack;
    word_t imem_rdata;

    logic  dmem_req;
    logic  dmem_we;
    word_t dmem_addr;
    word_t dmem_wdata;
    logic  dmem_ack;
    word_t dmem_rdata;

    word_t alu_x;
    word_t alu_y;
    logic  alu_zx;
    logic  alu_nx;
    logic  alu_zy;
    logic  alu_ny;
    logic  alu_f;
    logic  alu_no;
    word_t alu_out;
    logic  alu_zr;
    logic  alu_ng;

    // Controller side
    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_rdata,
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_ack, dmem_rdata,
        output alu_x, alu_y, alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no,
        input  alu_out, alu_zr, alu_ng
    );

    // Memory / ALU side
    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_rdata,
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_ack, dmem_rdata,
        input  alu_x, alu_y, alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no,
        output alu_out, alu_zr, alu_ng
    );

endinterface

// File: rtl/hack_jump_cond.sv
// Hack jump condition: j1 = less than zero, j2 = zero, j3 = greater than zero.
module hack_jump_cond (
    input  logic [2:0] jump,
    input  logic       zr,
    input  logic       ng,
    output logic       take_c
);

    // Combine the three comparison flags selected by the jump field
    always_comb begin
        take_c = (jump[2] & ng) | (jump[1] & zr) | (jump[0] & ~zr & ~ng);
    end

endmodule

// File: rtl/hack_cpu_ctrl.sv
// Multi-cycle Hack CPU controller: fetch, optional M read, execute,
// optional M write, write-back. Owns A, D and PC.
// Optional feature macro: HACK_CTRL_HALT_DETECT_EN (self-jump halts the core).
module hack_cpu_ctrl
    import hack_pkg::*;
#(
    parameter word_t RESET_PC = 16'h0000
) (
    input  logic            clk,
    input  logic            rst_n,
    hack_cpu_ctrl_if.master bus,
    output word_t           pc_o,
    output word_t           a_o,
    output word_t           d_o,
    output logic            halted
);

    state_t state;
    word_t  pc;
    word_t  a;
    word_t  d;
    word_t  ir;
    word_t  mreg;
    word_t  res;
    logic   take;
    logic   imem_req_r;
    logic   dmem_req_r;
    logic   dmem_we_r;
    logic   take_c;

    hack_jump_cond u_jump_cond (
        .jump   (ir[JUMP_HI:JUMP_LO]),
        .zr     (bus.alu_zr),
        .ng     (bus.alu_ng),
        .take_c (take_c)
    );

    // Bus outputs are direct taps of registers; addresses only change in WB
    assign bus.imem_req   = imem_req_r;
    assign bus.imem_addr  = pc;
    assign bus.dmem_req   = dmem_req_r;
    assign bus.dmem_we    = dmem_we_r;
    assign bus.dmem_addr  = a;
    assign bus.dmem_wdata = res;
    assign bus.alu_x      = d;
    assign bus.alu_y      = ir[IB_A] ? mreg : a;
    assign bus.alu_zx     = ir[COMP_HI];
    assign bus.alu_nx     = ir[COMP_HI-1];
    assign bus.alu_zy     = ir[COMP_HI-2];
    assign bus.alu_ny     = ir[COMP_HI-3];
    assign bus.alu_f      = ir[COMP_HI-4];
    assign bus.alu_no     = ir[COMP_LO];

    assign pc_o = pc;
    assign a_o  = a;
    assign d_o  = d;

`ifdef HACK_CTRL_HALT_DETECT_EN
    logic halted_r;
    assign halted = halted_r;
`else
    assign halted = 1'b0;
`endif

    // Controller state machine and architectural registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= FETCH;
            pc         <= RESET_PC;
            a          <= '0;
            d          <= '0;
            ir         <= '0;
            mreg       <= '0;
            res        <= '0;
            take       <= 1'b0;
            imem_req_r <= 1'b0;
            dmem_req_r <= 1'b0;
            dmem_we_r  <= 1'b0;
`ifdef HACK_CTRL_HALT_DETECT_EN
            halted_r   <= 1'b0;
`endif
        end else begin
            case (state)
                FETCH: begin
                    // First cycle after reset has no request yet; raise it here
                    if (!imem_req_r) begin
                        imem_req_r <= 1'b1;
                    end else if (bus.imem_ack) begin
                        imem_req_r <= 1'b0;
                        ir         <= bus.imem_rdata;
                        if (!is_c_instr(bus.imem_rdata)) begin
                            state <= WB;
                        end else if (bus.imem_rdata[IB_A]) begin
                            state      <= MEMRD;
                            dmem_req_r <= 1'b1;
                            dmem_we_r  <= 1'b0;
                        end else begin
                            state <= EXEC;
                        end
                    end
                end
                MEMRD: begin
                    if (bus.dmem_ack) begin
                        mreg       <= bus.dmem_rdata;
                        dmem_req_r <= 1'b0;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    res  <= bus.alu_out;
                    take <= take_c;
                    if (ir[DB_M]) begin
                        state      <= MEMWR;
                        dmem_req_r <= 1'b1;
                        dmem_we_r  <= 1'b1;
                    end else begin
                        state <= WB;
                    end
                end
                MEMWR: begin
                    if (bus.dmem_ack) begin
                        dmem_req_r <= 1'b0;
                        dmem_we_r  <= 1'b0;
                        state      <= WB;
                    end
                end
                WB: begin
                    // Jump target uses A before this instruction's own A write
                    if (!is_c_instr(ir)) begin
                        a  <= WORD_W'(ir[IB_TYPE-1:0]);
                        pc <= pc + WORD_W'(1);
                    end else begin
                        if (ir[DB_D]) d <= res;
                        if (ir[DB_A]) a <= res;
                        pc <= take ? a : pc + WORD_W'(1);
                    end
`ifdef HACK_CTRL_HALT_DETECT_EN
                    if (is_c_instr(ir) && take && (a == pc)) begin
                        state    <= HALT;
                        halted_r <= 1'b1;
                    end else begin
                        state      <= FETCH;
                        imem_req_r <= 1'b1;
                    end
`else
                    state      <= FETCH;
                    imem_req_r <= 1'b1;
`endif
                end
`ifdef HACK_CTRL_HALT_DETECT_EN
                HALT: begin
                    state <= HALT;
                end
`endif
                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hack_cpu_ctrl.sv
// Self-checking bench for hack_cpu_ctrl: vector table plus hand-written sequences,
// with memory responders and a reference Hack ALU.
module tb_hack_cpu_ctrl;

    logic        clk;
    logic        rst_n;
    logic [15:0] pc_o;
    logic [15:0] a_o;
    logic [15:0] d_o;
    logic        halted;

    hack_cpu_ctrl_if bus ();

    hack_cpu_ctrl #(.RESET_PC(16'h0000)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus),
        .pc_o   (pc_o),
        .a_o    (a_o),
        .d_o    (d_o),
        .halted (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference Hack ALU
    logic [15:0] ax, ay, af;
    always_comb begin
        ax = bus.alu_zx ? 16'h0000 : bus.alu_x;
        ax = bus.alu_nx ? ~ax : ax;
        ay = bus.alu_zy ? 16'h0000 : bus.alu_y;
        ay = bus.alu_ny ? ~ay : ay;
        af = bus.alu_f ? (ax + ay) : (ax & ay);
        af = bus.alu_no ? ~af : af;
        bus.alu_out = af;
        bus.alu_zr  = (af == 16'h0000);
        bus.alu_ng  = af[15];
    end

    logic [15:0] imem [0:255];
    logic [15:0] dmem [0:255];
    int iwait, dwait;

    // Monitor / responder state
    int cyc, rises, last_rise, prev_rise, i_cnt, d_cnt, dmem_done, unstable, n_wr;
    logic i_prev, d_prev;
    logic [15:0] snap_pc, snap_a, snap_d;
    logic [5:0]  snap_ctrl;
    logic [15:0] d_addr0, d_wdata0;
    logic        d_we0;
    logic [31:0] obs_w [0:7];

    // Memory responders (ack on the opposite edge) and fetch-start snapshots
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (!rst_n) begin
            rises         <= 0;
            last_rise     <= 0;
            prev_rise     <= 0;
            i_cnt         <= 0;
            d_cnt         <= 0;
            dmem_done     <= 0;
            unstable      <= 0;
            n_wr          <= 0;
            i_prev        <= 1'b0;
            d_prev        <= 1'b0;
            bus.imem_ack  <= 1'b0;
            bus.imem_rdata<= 16'h0000;
            bus.dmem_ack  <= 1'b0;
            bus.dmem_rdata<= 16'h0000;
        end else begin
            i_prev <= bus.imem_req;
            if (bus.imem_req) begin
                if (!i_prev) begin
                    rises     <= rises + 1;
                    prev_rise <= last_rise;
                    last_rise <= cyc;
                    snap_pc   <= pc_o;
                    snap_a    <= a_o;
                    snap_d    <= d_o;
                    snap_ctrl <= {bus.alu_zx, bus.alu_nx, bus.alu_zy,
                                  bus.alu_ny, bus.alu_f, bus.alu_no};
                end
                bus.imem_ack   <= ((i_prev ? i_cnt : 0) == iwait);
                bus.imem_rdata <= imem[bus.imem_addr[7:0]];
                i_cnt          <= (i_prev ? i_cnt : 0) + 1;
            end else begin
                bus.imem_ack <= 1'b0;
                i_cnt        <= 0;
            end

            d_prev <= bus.dmem_req;
            if (bus.dmem_req) begin
                if (!d_prev) begin
                    d_addr0  <= bus.dmem_addr;
                    d_we0    <= bus.dmem_we;
                    d_wdata0 <= bus.dmem_wdata;
                end else if (bus.dmem_addr !== d_addr0 || bus.dmem_we !== d_we0 ||
                             (bus.dmem_we && bus.dmem_wdata !== d_wdata0)) begin
                    unstable <= unstable + 1;
                end
                if ((d_prev ? d_cnt : 0) == dwait) begin
                    bus.dmem_ack   <= 1'b1;
                    bus.dmem_rdata <= dmem[bus.dmem_addr[7:0]];
                    dmem_done      <= dmem_done + 1;
                    if (bus.dmem_we && n_wr < 8) begin
                        obs_w[n_wr[2:0]] <= {bus.dmem_addr, bus.dmem_wdata};
                        n_wr             <= n_wr + 1;
                    end
                end else begin
                    bus.dmem_ack <= 1'b0;
                end
                d_cnt <= (d_prev ? d_cnt : 0) + 1;
            end else begin
                bus.dmem_ack <= 1'b0;
                d_cnt        <= 0;
            end
        end
    end

    int total, bad;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic load_and_release();
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic run_until(input int n, input int budget);
        int c;
        c = 0;
        while (rises < n && c < budget) begin
            @(posedge clk);
            #2;
            c++;
        end
        chk("progress", 32'(rises >= n), 32'd1);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) begin
            imem[i] = 16'h0000;
            dmem[i] = 16'h0000;
        end
    endtask

    typedef struct {
        logic [15:0] a0, d0, instr, mval;
        int          iw, dw;
        logic [15:0] exp_pc, exp_a, exp_d;
        logic [5:0]  exp_ctrl;
        int          exp_lat;
        bit          exp_wr;
        logic [15:0] exp_waddr, exp_wdata;
        int          exp_dmem;
    } vec_t;

    vec_t        vt [12];
    logic [31:0] exp_q [$];

    task automatic run_vec(input int idx, input vec_t v);
        logic [31:0] e;
        string nm;
        rst_n = 1'b0;
        clear_mem();
        imem[0] = v.d0;
        imem[1] = 16'hEC10;
        imem[2] = v.a0;
        imem[3] = v.instr;
        dmem[v.a0[7:0]] = v.mval;
        iwait = v.iw;
        dwait = v.dw;
        if (v.exp_wr) exp_q.push_back({v.exp_waddr, v.exp_wdata});
        load_and_release();
        run_until(5, 300);
        nm = $sformatf("v%0d", idx);
        chk({nm, " pc"},   32'(snap_pc),   32'(v.exp_pc));
        chk({nm, " a"},    32'(snap_a),    32'(v.exp_a));
        chk({nm, " d"},    32'(snap_d),    32'(v.exp_d));
        chk({nm, " ctrl"}, 32'(snap_ctrl), 32'(v.exp_ctrl));
        chk({nm, " lat"},  32'(last_rise - prev_rise), 32'(v.exp_lat));
        chk({nm, " dmem_xfers"}, 32'(dmem_done), 32'(v.exp_dmem));
        chk({nm, " stable"}, 32'(unstable), 32'd0);
        chk({nm, " writes"}, 32'(n_wr), 32'(exp_q.size()));
        for (int k = 0; k < n_wr && k < 8; k++) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
            chk({nm, " wr"}, obs_w[k], e);
        end
        exp_q.delete();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        iwait = 0;
        dwait = 0;
        clear_mem();

        //        a0      d0      instr     m       iw dw  pc      a       d       ctrl       lat wr waddr   wdata   ndm
        vt[0]  = '{16'd9,  16'd2, 16'h0005, 16'd0,  0, 0, 16'd4,  16'd5,  16'd2,  6'b000000, 2, 0, 16'd0,  16'd0,  0};
        vt[1]  = '{16'd5,  16'd2, 16'hEC10, 16'd0,  0, 0, 16'd4,  16'd5,  16'd5,  6'b110000, 3, 0, 16'd0,  16'd0,  0};
        vt[2]  = '{16'd100,16'd5, 16'hE7C8, 16'd0,  0, 3, 16'd4,  16'd100,16'd5,  6'b011111, 7, 1, 16'd100,16'd6,  1};
        vt[3]  = '{16'd40, 16'd0, 16'hE302, 16'd0,  0, 0, 16'd40, 16'd40, 16'd0,  6'b001100, 3, 0, 16'd0,  16'd0,  0};
        vt[4]  = '{16'd40, 16'd7, 16'hE302, 16'd0,  0, 0, 16'd4,  16'd40, 16'd7,  6'b001100, 3, 0, 16'd0,  16'd0,  0};
        vt[5]  = '{16'd50, 16'd3, 16'hFC10, 16'd9,  0, 0, 16'd4,  16'd50, 16'd9,  6'b110000, 4, 0, 16'd0,  16'd0,  1};
        vt[6]  = '{16'd7,  16'd1, 16'hEC10, 16'd0,  2, 0, 16'd4,  16'd7,  16'd7,  6'b110000, 5, 0, 16'd0,  16'd0,  0};
        vt[7]  = '{16'd30, 16'd5, 16'hE7E7, 16'd0,  0, 0, 16'd30, 16'd6,  16'd5,  6'b011111, 3, 0, 16'd0,  16'd0,  0};
        vt[8]  = '{16'd60, 16'd3, 16'hFDD8, 16'd20, 0, 1, 16'd4,  16'd60, 16'd21, 6'b110111, 7, 1, 16'd60, 16'd21, 2};
        vt[9]  = '{16'd12, 16'd4, 16'hEE94, 16'd0,  0, 0, 16'd12, 16'd12, 16'hFFFF,6'b111010, 3, 0, 16'd0,  16'd0,  0};
        vt[10] = '{16'd12, 16'd4, 16'hEA81, 16'd0,  0, 0, 16'd4,  16'd12, 16'd4,  6'b101010, 3, 0, 16'd0,  16'd0,  0};
        vt[11] = '{16'd61, 16'd1, 16'hFDD8, 16'h7FFF,1,0, 16'd4,  16'd61, 16'h8000,6'b110111, 6, 1, 16'd61, 16'h8000,2};

        // Reset state, then first fetch request on the first edge after release
        repeat (3) @(posedge clk);
        #1;
        chk("rst imem_req", 32'(bus.imem_req), 32'd0);
        chk("rst dmem_req", 32'(bus.dmem_req), 32'd0);
        chk("rst dmem_we",  32'(bus.dmem_we),  32'd0);
        chk("rst pc",       32'(pc_o), 32'd0);
        chk("rst a",        32'(a_o),  32'd0);
        chk("rst d",        32'(d_o),  32'd0);
        chk("rst halted",   32'(halted), 32'd0);
        chk("rst ctrl", 32'({bus.alu_zx, bus.alu_nx, bus.alu_zy, bus.alu_ny, bus.alu_f, bus.alu_no}), 32'd0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("first imem_req",  32'(bus.imem_req),  32'd1);
        chk("first imem_addr", 32'(bus.imem_addr), 32'd0);

        for (int i = 0; i < 12; i++) run_vec(i, vt[i]);

        // PC wraps from FFFF to 0000
        rst_n = 1'b0;
        clear_mem();
        iwait = 0;
        dwait = 0;
        imem[0]   = 16'hEEA0;   // A=-1
        imem[1]   = 16'hEA87;   // 0;JMP -> FFFF
        imem[255] = 16'h0007;   // @7 at FFFF
        load_and_release();
        run_until(3, 100);
        chk("wrap fetch ffff", 32'(snap_pc), 32'hFFFF);
        run_until(4, 100);
        chk("wrap pc", 32'(snap_pc), 32'h0000);
        chk("wrap a",  32'(snap_a),  32'h0007);

        // Self-jump at pc 3
        rst_n = 1'b0;
        clear_mem();
        imem[2] = 16'h0003;
        imem[3] = 16'hEA87;
        load_and_release();
`ifdef HACK_CTRL_HALT_DETECT_EN
        run_until(4, 100);
        repeat (20) @(posedge clk);
        #2;
        chk("halt halted", 32'(halted), 32'd1);
        chk("halt no refetch", 32'(rises), 32'd4);
        chk("halt imem_req", 32'(bus.imem_req), 32'd0);
`else
        run_until(8, 200);
        chk("selfjump pc", 32'(snap_pc), 32'd3);
        chk("selfjump halted", 32'(halted), 32'd0);
`endif

        // Reset asserted while a write is waiting for ack
        rst_n = 1'b0;
        clear_mem();
        imem[0] = 16'd5;
        imem[1] = 16'hEC10;
        imem[2] = 16'd100;
        imem[3] = 16'hE7C8;
        dwait = 20;
        load_and_release();
        begin
            int c;
            c = 0;
            while (!(bus.dmem_req && bus.dmem_we) && c < 100) begin
                @(posedge clk);
                #2;
                c++;
            end
        end
        chk("memwr reached", 32'(bus.dmem_req && bus.dmem_we), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort dmem_req", 32'(bus.dmem_req), 32'd0);
        chk("abort dmem_we",  32'(bus.dmem_we),  32'd0);
        chk("abort imem_req", 32'(bus.imem_req), 32'd0);
        chk("abort pc",       32'(pc_o),         32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
